// File: rtl/div_pkg.sv
// Shared constants for the sequential unsigned divider: FSM state encoding,
// default operand width and the divide-by-zero quotient pattern.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Quotient reported when the divisor is zero (all ones, RISC-V DIVU semantics).
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtraction of the divisor from the
// shifted partial remainder, computed WIDTH+1 bits wide as a + ~b + 1 on a
// ripple-carry adder. A non-negative trial yields quotient bit 1 and the
// difference as the new remainder; otherwise the shifted value is restored.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   shifted,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] next_r,
    output logic             q_bit
);

    logic [WIDTH:0] b_inv;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] carry;

    assign b_inv    = ~{1'b0, d};
    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_add
            assign diff[gi] = shifted[gi] ^ b_inv[gi] ^ carry[gi];
            // The carry out of the top bit is not needed: the sign lives in diff[WIDTH].
            if (gi < WIDTH) begin : g_carry
                assign carry[gi+1] = (shifted[gi] & b_inv[gi])
                                   | (carry[gi] & (shifted[gi] ^ b_inv[gi]));
            end
        end
    endgenerate

    // Partial remainder is always below the divisor, so the trial result is
    // negative exactly when its top bit is set.
    assign q_bit  = ~diff[WIDTH];
    assign next_r = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider for DIVU/REMU. Accepts one operand
// pair on a valid/ready handshake, produces one quotient bit per cycle and
// holds quotient/remainder until the consumer takes them.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    // All-ones at whatever WIDTH this instance uses.
    localparam logic [WIDTH-1:0] ZERO_Q   = {WIDTH{DIV_ZERO_Q[0]}};

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             div_zero_reg;

    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic             q_bit;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .shifted(({r_reg, q_reg[WIDTH-1]})),
        .d      (d_reg),
        .next_r (r_next),
        .q_bit  (q_bit)
    );

    assign q_next = {q_reg[WIDTH-2:0], q_bit};

    // FSM, iteration counter, working registers and result registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            r_reg         <= '0;
            q_reg         <= '0;
            d_reg         <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        q_reg   <= dividend;
                        d_reg   <= divisor;
                        r_reg   <= '0;
                        cnt_reg <= '0;
                        if (divisor == '0) begin
                            // Divide-by-zero skips iteration entirely.
                            quotient_reg  <= ZERO_Q;
                            remainder_reg <= dividend;
                            div_zero_reg  <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_reg   <= r_next;
                    q_reg   <= q_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        quotient_reg  <= q_next;
                        remainder_reg <= r_next;
                        div_zero_reg  <= 1'b0;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign div_zero  = div_zero_reg;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider that consumes the team's trial-subtraction datapath (a − b, two's-complement via adder with inverted b and carry-in 1).
- Sits beside the ALU in the execute stage and serves DIVU/REMU.
- Takes one dividend/divisor pair through a valid/ready handshake, runs one quotient bit per cycle, then holds the result until the consumer accepts it.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising-edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  operand pair present
in_ready  output  1  divider idle and able to accept operands
dividend  input  WIDTH  unsigned dividend, sampled on accept
divisor  input  WIDTH  unsigned divisor, sampled on accept
out_valid  output  1  quotient/remainder/div_zero valid
out_ready  input  1  consumer accepts result
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
div_zero  output  1  set with result when divisor was 0
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous and active-low.
- Reset (async, rstn=0):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, div_zero=0.
  - quotient=0, remainder=0, counter=0, internal R/Q/D registers=0.
  - Reset mid-RUN or mid-DONE aborts the operation; no result is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1. Accept occurs on the edge where in_valid && in_ready.
  - On accept: Q←dividend, D←divisor, R←0, cnt←0.
  - If divisor≠0, go to RUN.
  - If divisor==0, go directly to DONE with quotient=all-ones, remainder=dividend, div_zero=1 (RISC-V semantics).
- RUN (in_ready=0, in_valid ignored):
  - Each cycle, shifted = {R[WIDTH-2:0], Q[WIDTH-1]}, with an extra top bit R[WIDTH-1] kept as a (WIDTH+1)-bit value.
  - trial = shifted − {1'b0, D}, computed WIDTH+1 bits wide.
  - If trial is non-negative (MSB=0): R←trial[WIDTH-1:0], Q←{Q[WIDTH-2:0],1}.
  - Otherwise: R←shifted[WIDTH-1:0], Q←{Q[WIDTH-2:0],0}.
  - cnt increments every cycle. On the iteration where cnt==WIDTH−1, load quotient←final Q and remainder←final R, clear div_zero, and go to DONE.
- Latency:
  - Accept at edge k → out_valid visible after edge k+WIDTH (32 cycles for WIDTH=32).
  - Divide-by-zero: out_valid visible after edge k (1 cycle).
- DONE:
  - out_valid=1, in_ready=0.
  - quotient, remainder and div_zero are held stable while out_valid && !out_ready.
  - When out_ready=1: go to IDLE; out_valid drops and in_ready rises on the next cycle.
  - Results persist in their registers after the handshake until the next result is loaded.
  - No back-to-back accept in the same cycle as a result handoff.
- busy = (state≠IDLE).
- Arithmetic:
  - Unsigned only; signed handling belongs to the wrapper.
  - Dividend < divisor yields q=0, r=dividend.
  - All subtractions are modulo 2^(WIDTH+1); no overflow is possible.
- All outputs are registered or decoded from the state register only; there is no combinational path from input to output.

Decomposition:
- Shared package (div_pkg):
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - DIV_ZERO_Q = all-ones constant.
  - Default WIDTH.
- One sub-module, div_step: combinational, (WIDTH+1)-bit trial subtraction.
  - Built as a + ~b + 1 through the team's adder.
  - Takes {R,Qmsb} and D; returns next_R and q_bit.
- The FSM, counter and registers stay in seq_divider.

Test Plan:
- dividend=100, divisor=7, out_ready=1 → out_valid 32 cycles after accept, quotient=14, remainder=2, div_zero=0, in_ready=1 the following cycle.
- dividend=0xFFFFFFFF, divisor=0xFFFFFFFF → q=1, r=0. Then 0x80000000/0xFFFFFFFF → q=0, r=0x80000000. Then 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0.
- dividend=5, divisor=0 → out_valid one cycle after accept, quotient=0xFFFFFFFF, remainder=5, div_zero=1. Next op 9/3 → q=3, r=0, div_zero=0.
- Backpressure: 3/10 with out_ready=0 for 5 cycles after out_valid → q=0, r=3 held unchanged, in_ready=0. Also toggle in_valid with a new pair during RUN → ignored; result unaffected.
- Reset mid-op: assert rstn=0 asynchronously 10 cycles into RUN → outputs clear immediately (out_valid=0, in_ready=1 after release, quotient=remainder=0). New op 50/6 → q=8, r=2.
- Random regression: 1000 random pairs including divisor=1, divisor>dividend and zero dividend, checked against a reference model for q, r, latency and handshake ordering.
